prescaled_step_counter: RTL and testbench

//   Programmable-rate step counter for game timing (animation frames, spawn timers).
//   A prescaler divides clk by a runtime divisor and each prescaler step moves a modulo-MAX count.

---
 rtl/prescaled_step_counter_if.sv | 25 ++
 rtl/prescaled_step_counter.sv | 74 +++++++
 tb/tb_prescaled_step_counter.sv | 116 +++++++++++
 3 files changed

// File: rtl/prescaled_step_counter_if.sv
// prescaled_step_counter_if: control inputs and count/pulse outputs of one game timer
interface prescaled_step_counter_if #(
   parameter int CW = 32,
   parameter int PW = 32
);
   logic          en;
   logic          clr;
   logic          load;
   logic [CW-1:0] load_val;
   logic [PW-1:0] div;
   logic [1:0]    mode;
   logic          dir;
   logic [CW-1:0] count;
   logic          tick;
   logic          tc;
   logic          busy;
   modport master (
      output en, clr, load, load_val, div, mode, dir,
      input  count, tick, tc, busy
   );
   modport slave (
      input  en, clr, load, load_val, div, mode, dir,
      output count, tick, tc, busy
   );
endinterface

// File: rtl/prescaled_step_counter.sv
// prescaled_step_counter: runtime-divided modulo-MAX up/down timer with wrap, saturate and one-shot modes
module prescaled_step_counter #(
   parameter int              CW  = 32,
   parameter int              PW  = 32,
   parameter longint unsigned MAX = 100000
) (
   input logic                    clk,
   input logic                    rst,
   prescaled_step_counter_if.slave bus
);
   typedef enum logic {RUN, DONE} state_t;
   localparam logic [CW-1:0] TOP = CW'(MAX - 1);
   state_t        state, state_nx;
   logic [PW-1:0] pcnt, pcnt_nx, div_last;
   logic [CW-1:0] count_q, count_nx, term, start;
   logic          tick_q, tc_q, tick_nx, tc_nx, step, at_t;
   assign bus.count = count_q;
   assign bus.tick  = tick_q;
   assign bus.tc    = tc_q;
   assign bus.busy  = state == RUN;
   // step decode: a zero divisor behaves as 1, and >= lets a shrunken divisor fire at once
   always_comb begin
      div_last = (bus.div == '0) ? '0 : bus.div - PW'(1);
      term     = bus.dir ? '0 : TOP;
      start    = bus.dir ? TOP : '0;
      at_t     = count_q == term;
      step     = bus.en && state == RUN && pcnt >= div_last;
   end
   // next count, prescaler, FSM and pulses; clr beats load beats step
   always_comb begin
      count_nx = count_q;
      pcnt_nx  = pcnt;
      state_nx = state;
      tick_nx  = 1'b0;
      tc_nx    = 1'b0;
      if (bus.clr) begin
         count_nx = start;
         pcnt_nx  = '0;
         state_nx = RUN;
      end else if (bus.load) begin
         count_nx = (bus.load_val > TOP) ? TOP : bus.load_val;
         pcnt_nx  = '0;
         state_nx = RUN;
      end else if (step) begin
         pcnt_nx = '0;
         tick_nx = 1'b1;
         tc_nx   = at_t;
         if (!at_t)
            count_nx = bus.dir ? count_q - CW'(1) : count_q + CW'(1);
         else if (bus.mode == 2'b00 || bus.mode == 2'b11)
            count_nx = start;
         else if (bus.mode == 2'b10)
            state_nx = DONE;
      end else if (bus.en && state == RUN) begin
         pcnt_nx = pcnt + PW'(1);
      end
   end
   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         pcnt    <= '0;
         state   <= RUN;
         tick_q  <= 1'b0;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_nx;
         pcnt    <= pcnt_nx;
         state   <= state_nx;
         tick_q  <= tick_nx;
         tc_q    <= tc_nx;
      end
   end
endmodule

// File: tb/tb_prescaled_step_counter.sv
// tb_prescaled_step_counter: vector table plus corner-case sequences checked through a scoreboard queue
module tb_prescaled_step_counter;
   localparam int              CW  = 32;
   localparam int              PW  = 32;
   localparam longint unsigned MAX = 5;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   prescaled_step_counter_if #(.CW(CW), .PW(PW)) bus();
   prescaled_step_counter #(.CW(CW), .PW(PW), .MAX(MAX)) dut (.clk(clk), .rst(rst), .bus(bus));
   typedef struct {
      logic [31:0] cnt;
      logic        tk, tcx, bz;
      string       nm;
   } exp_t;
   typedef struct {
      int r, e, c, l, lv, dv, md, dr, cnt, tk, tcx, bz;
   } vec_t;
   exp_t sb[$];
   vec_t tbl[26];
   int   errors = 0;
   int   checks = 0;
   // apply one cycle of inputs, queue what the outputs must be after the edge, then compare
   task automatic drive(input int r, e, c, l, lv, dv, md, dr, cnt, tk, tcx, bz, input string nm);
      exp_t x;
      rst          = 1'(r);
      bus.en       = 1'(e);
      bus.clr      = 1'(c);
      bus.load     = 1'(l);
      bus.load_val = lv;
      bus.div      = dv;
      bus.mode     = 2'(md);
      bus.dir      = 1'(dr);
      x.cnt = cnt;
      x.tk  = 1'(tk);
      x.tcx = 1'(tcx);
      x.bz  = 1'(bz);
      x.nm  = nm;
      sb.push_back(x);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      checks++;
      if ({bus.count, bus.tick, bus.tc, bus.busy} !== {x.cnt, x.tk, x.tcx, x.bz}) begin
         errors++;
         $display("FAIL %s: got count=%0d tick=%b tc=%b busy=%b, want count=%0d tick=%b tc=%b busy=%b",
                  x.nm, bus.count, bus.tick, bus.tc, bus.busy, x.cnt, x.tk, x.tcx, x.bz);
      end
   endtask
   initial begin
      //        r e c l lv dv md dr  cnt tk tc bz
      tbl = '{'{1,0,0,0, 0, 1, 0, 0,  0, 0, 0, 1},
              '{0,1,0,0, 0, 1, 0, 1,  4, 1, 1, 1},
              '{0,1,0,0, 0, 1, 0, 1,  3, 1, 0, 1},
              '{0,1,0,0, 0, 1, 0, 1,  2, 1, 0, 1},
              '{0,1,0,0, 0, 1, 0, 1,  1, 1, 0, 1},
              '{0,1,0,0, 0, 1, 0, 1,  0, 1, 0, 1},
              '{0,1,0,0, 0, 1, 0, 1,  4, 1, 1, 1},
              '{0,1,0,0, 0, 1, 1, 0,  4, 1, 1, 1},
              '{0,1,0,0, 0, 1, 1, 0,  4, 1, 1, 1},
              '{0,1,1,0, 0, 1, 1, 0,  0, 0, 0, 1},
              '{0,1,0,0, 0, 1, 1, 0,  1, 1, 0, 1},
              '{0,1,0,0, 0, 1, 1, 0,  2, 1, 0, 1},
              '{0,1,0,0, 0, 1, 1, 0,  3, 1, 0, 1},
              '{0,1,0,0, 0, 1, 1, 0,  4, 1, 0, 1},
              '{0,1,0,0, 0, 1, 1, 0,  4, 1, 1, 1},
              '{0,1,0,0, 0, 1, 1, 0,  4, 1, 1, 1},
              '{0,1,1,1, 3, 1, 1, 0,  0, 0, 0, 1},
              '{0,1,0,1, 9, 1, 1, 0,  4, 0, 0, 1},
              '{0,0,0,1, 2, 1, 1, 0,  2, 0, 0, 1},
              '{0,0,0,0, 0, 1, 1, 0,  2, 0, 0, 1},
              '{0,1,0,0, 0, 1, 0, 1,  1, 1, 0, 1},
              '{0,1,0,1, 4, 1, 0, 1,  4, 0, 0, 1},
              '{0,1,0,0, 0, 1, 0, 1,  3, 1, 0, 1},
              '{0,1,1,0, 0, 1, 0, 1,  4, 0, 0, 1},
              '{0,1,0,0, 0, 0, 0, 1,  3, 1, 0, 1},
              '{0,1,0,0, 0, 0, 0, 1,  2, 1, 0, 1}};
      foreach (tbl[i])
         drive(tbl[i].r, tbl[i].e, tbl[i].c, tbl[i].l, tbl[i].lv, tbl[i].dv, tbl[i].md, tbl[i].dr,
               tbl[i].cnt, tbl[i].tk, tbl[i].tcx, tbl[i].bz, $sformatf("vec%0d", i));
      drive(1, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 1, "div4_rst");
      for (int k = 1; k <= 20; k++)
         drive(0, 1, 0, 0, 0, 4, 0, 0, (k / 4) % 5, int'(k % 4 == 0), int'(k == 20), 1, $sformatf("div4_c%0d", k));
      drive(0, 0, 0, 1, 2, 2, 2, 0, 2, 0, 0, 1, "os_load2");
      for (int k = 1; k <= 6; k++)
         drive(0, 1, 0, 0, 0, 2, 2, 0, (2 + k / 2 > 4) ? 4 : 2 + k / 2, int'(k % 2 == 0), int'(k == 6),
               int'(k != 6), $sformatf("os_run%0d", k));
      for (int k = 1; k <= 20; k++)
         drive(0, 1, 0, 0, 0, 2, 2, 0, 4, 0, 0, 0, $sformatf("os_done%0d", k));
      drive(0, 1, 0, 1, 0, 2, 2, 0, 0, 0, 0, 1, "os_reload");
      drive(0, 1, 0, 0, 0, 2, 2, 0, 0, 0, 0, 1, "os_resume1");
      drive(0, 1, 0, 0, 0, 2, 2, 0, 1, 1, 0, 1, "os_resume2");
      drive(0, 1, 0, 1, 4, 1, 2, 0, 4, 0, 0, 1, "os_load4");
      drive(0, 1, 0, 0, 0, 1, 2, 0, 4, 1, 1, 0, "os_fire");
      drive(0, 1, 0, 0, 0, 1, 2, 0, 4, 0, 0, 0, "os_idle");
      drive(1, 1, 0, 0, 0, 1, 2, 0, 0, 0, 0, 1, "rst_done");
      drive(0, 1, 1, 0, 0, 4, 0, 0, 0, 0, 0, 1, "frz_clr");
      drive(0, 1, 0, 0, 0, 4, 0, 0, 0, 0, 0, 1, "frz_p1");
      drive(0, 1, 0, 0, 0, 4, 0, 0, 0, 0, 0, 1, "frz_p2");
      for (int k = 1; k <= 10; k++)
         drive(0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 1, $sformatf("frz_hold%0d", k));
      drive(0, 1, 0, 0, 0, 4, 0, 0, 0, 0, 0, 1, "frz_p3");
      drive(0, 1, 0, 0, 0, 4, 0, 0, 1, 1, 0, 1, "frz_step");
      drive(0, 1, 1, 0, 0, 8, 0, 0, 0, 0, 0, 1, "div8_clr");
      for (int k = 1; k <= 5; k++)
         drive(0, 1, 0, 0, 0, 8, 0, 0, 0, 0, 0, 1, $sformatf("div8_p%0d", k));
      drive(0, 1, 0, 0, 0, 2, 0, 0, 1, 1, 0, 1, "div2_now");
      drive(0, 1, 0, 0, 0, 2, 0, 0, 1, 0, 0, 1, "div2_p");
      drive(0, 1, 0, 0, 0, 2, 0, 0, 2, 1, 0, 1, "div2_step");
      drive(1, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 1, "rst_mid");
      drive(0, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 1, "post_rst_p");
      drive(0, 1, 0, 0, 0, 2, 0, 0, 1, 1, 0, 1, "post_rst_step");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
